regfile_wb_arbiter: RTL and testbench

//   Shares the single write port of the 32x64 integer register file between two writeback

---
 rtl/regfile_wb_pkg.sv | 25 ++
 rtl/regfile_wb_arbiter_fifo.sv | 66 ++++++
 rtl/regfile_wb_arbiter.sv | 131 +++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_wb_pkg.sv
// ============================================================================
// Module  : regfile_wb_pkg
// Brief   : Shared types and widths for the register-file writeback arbiter.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

package regfile_wb_pkg;

    localparam int XLEN = 64;
    localparam int AW   = 5;

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_MEM = 1'b1
    } src_e;

    typedef struct packed {
        logic [AW-1:0]   rd;
        logic [XLEN-1:0] data;
    } wb_req_t;

endpackage

`default_nettype wire

// File: rtl/regfile_wb_arbiter_fifo.sv
// ============================================================================
// Module  : wb_fifo
// Brief   : Synchronous writeback-request FIFO, full/empty derived from count.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_fifo
    import regfile_wb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic    clk,
    input  logic    reset,
    input  logic    i_push,
    input  wb_req_t i_data,
    input  logic    i_pop,
    output wb_req_t o_head,
    output logic    o_empty,
    output logic    o_full
);

    localparam int                 c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int                 c_CNT_W = $clog2(DEPTH + 1);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE = c_PTR_W'(1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_CNT_FULL = c_CNT_W'(DEPTH);

    wb_req_t              r_mem [DEPTH];
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_CNT_W-1:0]   r_count;
    logic                 w_do_push;
    logic                 w_do_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == c_CNT_FULL);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_head    = r_mem[r_rd_ptr];

    // DEPTH is a power of two, so the pointers wrap on natural overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + c_CNT_ONE;
            end else if (w_do_pop && !w_do_push) begin
                r_count <= r_count - c_CNT_ONE;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
// ============================================================================
// Module  : regfile_wb_arbiter
// Brief   : Round-robin arbiter sharing the RF write port between ALU and load
//           writebacks. Define WB_ARB_MEM_PRIORITY_EN for fixed MEM priority.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_wb_arbiter
    import regfile_wb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            alu_valid,
    output logic            alu_ready,
    input  logic [AW-1:0]   alu_rd,
    input  logic [XLEN-1:0] alu_data,
    input  logic            mem_valid,
    output logic            mem_ready,
    input  logic [AW-1:0]   mem_rd,
    input  logic [XLEN-1:0] mem_data,
    output logic            rf_we,
    output logic [AW-1:0]   rf_rd,
    output logic [XLEN-1:0] rf_wdata,
    output logic            rf_src,
    output logic            busy
);

    wb_req_t         w_alu_in;
    wb_req_t         w_mem_in;
    wb_req_t         w_alu_head;
    wb_req_t         w_mem_head;
    wb_req_t         w_sel;
    src_e            w_sel_src;
    logic            w_alu_empty;
    logic            w_alu_full;
    logic            w_mem_empty;
    logic            w_mem_full;
    logic            w_alu_push;
    logic            w_mem_push;
    logic            w_grant_alu;
    logic            w_grant_mem;
    logic            w_grant;

    logic            r_we;
    logic [AW-1:0]   r_rd;
    logic [XLEN-1:0] r_wdata;
    src_e            r_src;

    assign alu_ready  = !w_alu_full;
    assign mem_ready  = !w_mem_full;
    assign w_alu_push = alu_valid && alu_ready;
    assign w_mem_push = mem_valid && mem_ready;
    assign w_alu_in   = '{rd: alu_rd, data: alu_data};
    assign w_mem_in   = '{rd: mem_rd, data: mem_data};

    wb_fifo #(.DEPTH(DEPTH)) u_alu_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_alu_push),
        .i_data  (w_alu_in),
        .i_pop   (w_grant_alu),
        .o_head  (w_alu_head),
        .o_empty (w_alu_empty),
        .o_full  (w_alu_full)
    );

    wb_fifo #(.DEPTH(DEPTH)) u_mem_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_mem_push),
        .i_data  (w_mem_in),
        .i_pop   (w_grant_mem),
        .o_head  (w_mem_head),
        .o_empty (w_mem_empty),
        .o_full  (w_mem_full)
    );

`ifdef WB_ARB_MEM_PRIORITY_EN
    assign w_grant_mem = !w_mem_empty;
    assign w_grant_alu = !w_alu_empty && w_mem_empty;
`else
    src_e r_rr;

    // On a tie the source opposite the last grant wins; reset favours ALU first.
    assign w_grant_alu = !w_alu_empty && (w_mem_empty || (r_rr == SRC_MEM));
    assign w_grant_mem = !w_mem_empty && (w_alu_empty || (r_rr == SRC_ALU));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rr <= SRC_MEM;
        end else if (w_grant_alu) begin
            r_rr <= SRC_ALU;
        end else if (w_grant_mem) begin
            r_rr <= SRC_MEM;
        end
    end
`endif

    assign w_grant   = w_grant_alu || w_grant_mem;
    assign w_sel     = w_grant_mem ? w_mem_head : w_alu_head;
    assign w_sel_src = w_grant_mem ? SRC_MEM : SRC_ALU;

    // An x0 head is still consumed and loaded, but never raises RegWrite.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_we    <= 1'b0;
            r_rd    <= '0;
            r_wdata <= '0;
            r_src   <= SRC_ALU;
        end else if (w_grant) begin
            r_we    <= (w_sel.rd != '0);
            r_rd    <= w_sel.rd;
            r_wdata <= w_sel.data;
            r_src   <= w_sel_src;
        end else begin
            r_we    <= 1'b0;
        end
    end

    assign rf_we    = r_we;
    assign rf_rd    = r_rd;
    assign rf_wdata = r_wdata;
    assign rf_src   = r_src;
    assign busy     = !w_alu_empty || !w_mem_empty || r_we;

endmodule

`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
// ============================================================================
// Module  : tb_regfile_wb_arbiter
// Brief   : Self-checking bench for regfile_wb_arbiter against a queue model.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile_wb_arbiter;
    import regfile_wb_pkg::*;

    localparam int DEPTH = 2;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            alu_valid = 1'b0;
    logic            alu_ready;
    logic [AW-1:0]   alu_rd = '0;
    logic [XLEN-1:0] alu_data = '0;
    logic            mem_valid = 1'b0;
    logic            mem_ready;
    logic [AW-1:0]   mem_rd = '0;
    logic [XLEN-1:0] mem_data = '0;
    logic            rf_we;
    logic [AW-1:0]   rf_rd;
    logic [XLEN-1:0] rf_wdata;
    logic            rf_src;
    logic            busy;

    int total = 0;
    int bad   = 0;

    // Reference model: one queue per source plus the last-granted source.
    wb_req_t         q_alu[$];
    wb_req_t         q_mem[$];
    int              m_last = 1;
    logic            m_we = 1'b0;
    logic [AW-1:0]   m_rd = '0;
    logic [XLEN-1:0] m_wdata = '0;
    logic            m_src = 1'b0;
    bit              acc_alu;
    bit              acc_mem;

    regfile_wb_arbiter #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .alu_valid (alu_valid),
        .alu_ready (alu_ready),
        .alu_rd    (alu_rd),
        .alu_data  (alu_data),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_rd    (mem_rd),
        .mem_data  (mem_data),
        .rf_we     (rf_we),
        .rf_rd     (rf_rd),
        .rf_wdata  (rf_wdata),
        .rf_src    (rf_src),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Advance the model by one clock edge, then step the DUT and settle.
    task automatic cycle();
        wb_req_t h;
        bit ga;
        bit gm;
        acc_alu = alu_valid && (q_alu.size() < DEPTH);
        acc_mem = mem_valid && (q_mem.size() < DEPTH);
`ifdef WB_ARB_MEM_PRIORITY_EN
        gm = (q_mem.size() > 0);
        ga = !gm && (q_alu.size() > 0);
`else
        if (q_alu.size() > 0 && q_mem.size() > 0) begin
            ga = (m_last == 1);
            gm = !ga;
        end else begin
            ga = (q_alu.size() > 0);
            gm = (q_mem.size() > 0);
        end
`endif
        if (reset) begin
            q_alu.delete();
            q_mem.delete();
            m_last = 1; m_we = 0; m_rd = '0; m_wdata = '0; m_src = 0;
            acc_alu = 0; acc_mem = 0;
        end else begin
            if (ga || gm) begin
                h = ga ? q_alu.pop_front() : q_mem.pop_front();
                m_we = (h.rd != 0); m_rd = h.rd; m_wdata = h.data;
                m_src = gm; m_last = gm ? 1 : 0;
            end else begin
                m_we = 0;
            end
            if (acc_alu) begin h.rd = alu_rd; h.data = alu_data; q_alu.push_back(h); end
            if (acc_mem) begin h.rd = mem_rd; h.data = mem_data; q_mem.push_back(h); end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1; alu_valid = 0; mem_valid = 0;
        cycle();
        reset = 0;
    endtask

    task automatic test_reset();
        reset = 1; alu_valid = 0; mem_valid = 0;
        cycle();
        cycle();
        reset = 0;
        total++; if (alu_ready !== 1'b1) begin bad++; $display("FAIL reset_alu_ready: got %b want 1", alu_ready); end
        total++; if (mem_ready !== 1'b1) begin bad++; $display("FAIL reset_mem_ready: got %b want 1", mem_ready); end
        total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL reset_rf_we: got %b want 0", rf_we); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (rf_rd !== '0 || rf_wdata !== '0 || rf_src !== 1'b0)
            begin bad++; $display("FAIL reset_rf_regs: got rd=%0d wdata=%0h src=%b want 0", rf_rd, rf_wdata, rf_src); end
    endtask

    task automatic test_single();
        alu_valid = 1; alu_rd = 5; alu_data = 64'hAA;
        cycle();
        alu_valid = 0;
        total++; if (rf_we !== 1'b0 || busy !== 1'b1)
            begin bad++; $display("FAIL single_e1: got we=%b busy=%b want 0 1", rf_we, busy); end
        cycle();
        total++; if (rf_we !== 1'b1 || rf_rd !== 5'd5 || rf_wdata !== 64'hAA || rf_src !== 1'b0)
            begin bad++; $display("FAIL single_e2: got we=%b rd=%0d wdata=%0h src=%b want 1 5 aa 0", rf_we, rf_rd, rf_wdata, rf_src); end
        cycle();
        total++; if (rf_we !== 1'b0 || busy !== 1'b0)
            begin bad++; $display("FAIL single_idle: got we=%b busy=%b want 0 0", rf_we, busy); end
    endtask

    task automatic test_alternate();
        int ia = 0;
        int im = 0;
        int first = -1;
        int last = -1;
        logic [AW-1:0] seen[$];
        logic [AW-1:0] exp_seq[6];
`ifdef WB_ARB_MEM_PRIORITY_EN
        exp_seq = '{5'd11, 5'd12, 5'd13, 5'd1, 5'd2, 5'd3};
`else
        exp_seq = '{5'd1, 5'd11, 5'd2, 5'd12, 5'd3, 5'd13};
`endif
        do_reset();
        for (int c = 0; c < 20; c++) begin
            alu_valid = (ia < 3); alu_rd = AW'(ia + 1);  alu_data = XLEN'(100 + ia);
            mem_valid = (im < 3); mem_rd = AW'(im + 11); mem_data = XLEN'(200 + im);
            cycle();
            if (acc_alu) ia++;
            if (acc_mem) im++;
            total++; if (rf_we !== m_we || rf_rd !== m_rd || rf_wdata !== m_wdata)
                begin bad++; $display("FAIL alt_model c=%0d: got we=%b rd=%0d want we=%b rd=%0d", c, rf_we, rf_rd, m_we, m_rd); end
            if (rf_we === 1'b1) begin
                seen.push_back(rf_rd);
                if (first < 0) first = c;
                last = c;
            end
        end
        alu_valid = 0; mem_valid = 0;
        total++; if (seen.size() != 6) begin bad++; $display("FAIL alt_count: got %0d want 6", seen.size()); end
        for (int k = 0; k < 6 && k < seen.size(); k++) begin
            total++; if (seen[k] !== exp_seq[k])
                begin bad++; $display("FAIL alt_order[%0d]: got %0d want %0d", k, seen[k], exp_seq[k]); end
        end
        total++; if (last - first != 5) begin bad++; $display("FAIL alt_rate: got span %0d want 5", last - first); end
    endtask

    task automatic test_flood();
        int ia = 0;
        int im = 0;
        bit saw_full = 0;
        logic [AW-1:0] alu_seen[$];
        do_reset();
        for (int c = 0; c < 30; c++) begin
            alu_valid = (ia < 4); alu_rd = AW'(20 + ia); alu_data = XLEN'(64'h1000 + ia);
            mem_valid = (im < 4); mem_rd = AW'(24 + im); mem_data = XLEN'(64'h2000 + im);
            cycle();
            if (acc_alu) ia++;
            if (acc_mem) im++;
            if (alu_ready === 1'b0) saw_full = 1;
            total++; if (alu_ready !== (q_alu.size() < DEPTH) || rf_we !== m_we || rf_rd !== m_rd)
                begin bad++; $display("FAIL flood_model c=%0d: got rdy=%b we=%b rd=%0d want rdy=%b we=%b rd=%0d",
                                      c, alu_ready, rf_we, rf_rd, q_alu.size() < DEPTH, m_we, m_rd); end
            if (rf_we === 1'b1 && rf_src === 1'b0) alu_seen.push_back(rf_rd);
        end
        alu_valid = 0; mem_valid = 0;
        total++; if (!saw_full) begin bad++; $display("FAIL flood_ready_low: got never-low want low"); end
        total++; if (alu_seen.size() != 4) begin bad++; $display("FAIL flood_count: got %0d want 4", alu_seen.size()); end
        for (int k = 0; k < 4 && k < alu_seen.size(); k++) begin
            total++; if (alu_seen[k] !== AW'(20 + k))
                begin bad++; $display("FAIL flood_order[%0d]: got %0d want %0d", k, alu_seen[k], 20 + k); end
        end
    endtask

    task automatic test_x0();
        do_reset();
        alu_valid = 1; alu_rd = 0; alu_data = 64'hFF;
        cycle();
        alu_rd = 7; alu_data = 64'h77;
        total++; if (rf_we !== 1'b0 || busy !== 1'b1)
            begin bad++; $display("FAIL x0_e1: got we=%b busy=%b want 0 1", rf_we, busy); end
        cycle();
        alu_valid = 0;
        total++; if (rf_we !== 1'b0 || busy !== 1'b1)
            begin bad++; $display("FAIL x0_slot: got we=%b busy=%b want 0 1", rf_we, busy); end
        cycle();
        total++; if (rf_we !== 1'b1 || rf_rd !== 5'd7 || rf_wdata !== 64'h77 || busy !== 1'b1)
            begin bad++; $display("FAIL x0_next: got we=%b rd=%0d wdata=%0h busy=%b want 1 7 77 1", rf_we, rf_rd, rf_wdata, busy); end
        cycle();
    endtask

    task automatic test_reset_mid();
        int writes = 0;
        do_reset();
        for (int k = 0; k < 2; k++) begin
            alu_valid = 1; alu_rd = AW'(3 + k);  alu_data = XLEN'(64'h30 + k);
            mem_valid = 1; mem_rd = AW'(13 + k); mem_data = XLEN'(64'h130 + k);
            cycle();
        end
        alu_valid = 0; mem_valid = 0;
        reset = 1;
        cycle();
        reset = 0;
        total++; if (rf_we !== 1'b0 || busy !== 1'b0 || alu_ready !== 1'b1 || mem_ready !== 1'b1)
            begin bad++; $display("FAIL rstmid_state: got we=%b busy=%b ar=%b mr=%b want 0 0 1 1", rf_we, busy, alu_ready, mem_ready); end
        for (int c = 0; c < 6; c++) begin
            cycle();
            if (rf_we === 1'b1) writes++;
        end
        total++; if (writes != 0) begin bad++; $display("FAIL rstmid_leak: got %0d writes want 0", writes); end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            if (!alu_valid || acc_alu) begin
                alu_valid = ($urandom_range(0, 99) < 60);
                alu_rd    = AW'($urandom_range(0, 31));
                alu_data  = {$urandom, $urandom};
            end
            if (!mem_valid || acc_mem) begin
                mem_valid = ($urandom_range(0, 99) < 60);
                mem_rd    = AW'($urandom_range(0, 31));
                mem_data  = {$urandom, $urandom};
            end
            cycle();
            total++; if (rf_we !== m_we || rf_rd !== m_rd || rf_wdata !== m_wdata || (m_we && rf_src !== m_src))
                begin bad++; $display("FAIL rand_rf c=%0d: got we=%b rd=%0d wd=%0h src=%b want we=%b rd=%0d wd=%0h src=%b",
                                      c, rf_we, rf_rd, rf_wdata, rf_src, m_we, m_rd, m_wdata, m_src); end
            total++; if (alu_ready !== (q_alu.size() < DEPTH) || mem_ready !== (q_mem.size() < DEPTH))
                begin bad++; $display("FAIL rand_ready c=%0d: got %b%b want %b%b", c, alu_ready, mem_ready,
                                      q_alu.size() < DEPTH, q_mem.size() < DEPTH); end
            total++; if (busy !== (q_alu.size() > 0 || q_mem.size() > 0 || m_we))
                begin bad++; $display("FAIL rand_busy c=%0d: got %b want %b", c, busy, q_alu.size() > 0 || q_mem.size() > 0 || m_we); end
        end
        alu_valid = 0; mem_valid = 0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_alternate();
        test_flood();
        test_x0();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "bench timeout");
    end

endmodule

`default_nettype wire
